// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register write-latency scoreboard producing ID stall,
// front-end flush, a busy indication and a saturating stall counter.
module hazard_scoreboard #(
  parameter int unsigned NUM_REGS    = 32,
  parameter int unsigned REG_W       = $clog2(NUM_REGS),
  parameter int unsigned LAT_W       = 3,
  parameter int unsigned FLUSH_EXTRA = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic [LAT_W-1:0] id_latency,
  input  logic             branch_taken,
  input  logic             mem_wait,
  output logic             stall,
  output logic             flush,
  output logic             busy,
  output logic [CNT_W-1:0] stall_count
);

  // Flush window counter must be able to hold FLUSH_EXTRA (at least one bit).
  localparam int unsigned FC_W = (FLUSH_EXTRA > 0) ? $clog2(FLUSH_EXTRA + 1) : 1;
  localparam logic [FC_W-1:0]  FC_LOAD = FC_W'(FLUSH_EXTRA);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Remaining bubbles before each register's pending write is usable.
  // Register 0 is hard-wired zero and is not stored.
  logic [LAT_W-1:0] pend [1:NUM_REGS-1];
  logic [FC_W-1:0]  flush_cnt;

  logic [LAT_W-1:0] pend_rs1;
  logic [LAT_W-1:0] pend_rs2;
  logic [LAT_W-1:0] pend_rd;
  logic             raw_hazard;
  logic             waw_hazard;
  logic             data_hazard;
  logic             issue;
  logic             rd_load;

  // Look up pending state for the ID operands and OR-reduce the busy flag.
  always_comb begin
    pend_rs1 = '0;
    pend_rs2 = '0;
    pend_rd  = '0;
    busy     = 1'b0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      if (id_rs1 == REG_W'(r)) pend_rs1 = pend[r];
      if (id_rs2 == REG_W'(r)) pend_rs2 = pend[r];
      if (id_rd  == REG_W'(r)) pend_rd  = pend[r];
      if (pend[r] != '0) busy = 1'b1;
    end
  end

  // Hazard detection and stall/flush arbitration; flush wins over data stalls
  // because the ID instruction is being killed anyway.
  always_comb begin
    raw_hazard  = (id_rs1_used && (id_rs1 != '0) && (pend_rs1 != '0)) ||
                  (id_rs2_used && (id_rs2 != '0) && (pend_rs2 != '0));
    waw_hazard  = id_reg_write && (id_rd != '0) && (pend_rd > id_latency);
    data_hazard = id_valid && (raw_hazard || waw_hazard);
    flush       = !mem_wait && (branch_taken || (flush_cnt != '0));
    stall       = mem_wait || (data_hazard && !flush);
    issue       = id_valid && !stall && !flush;
    rd_load     = issue && id_reg_write && (id_rd != '0);
  end

  // Per-register countdown; an issuing writer reloads its destination entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 1; r < NUM_REGS; r++) begin
        pend[r] <= '0;
      end
    end else if (!mem_wait) begin
      for (int unsigned r = 1; r < NUM_REGS; r++) begin
        if (rd_load && (id_rd == REG_W'(r))) begin
          pend[r] <= id_latency;
        end else if (pend[r] != '0) begin
          pend[r] <= pend[r] - LAT_W'(1);
        end
      end
    end
  end

  // Flush window: reloads on every taken branch, frozen while memory waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt <= '0;
    end else if (!mem_wait) begin
      if (branch_taken) begin
        flush_cnt <= FC_LOAD;
      end else if (flush_cnt != '0) begin
        flush_cnt <= flush_cnt - FC_W'(1);
      end
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall && (stall_count != CNT_MAX)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed cycle vectors; the driver queues the
// expected outputs for each cycle and a monitor compares them mid-cycle.
module tb_hazard_scoreboard;

  localparam int unsigned REG_W = 5;
  localparam int unsigned LAT_W = 3;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             id_valid = 1'b0;
  logic [REG_W-1:0] id_rs1 = '0;
  logic [REG_W-1:0] id_rs2 = '0;
  logic             id_rs1_used = 1'b0;
  logic             id_rs2_used = 1'b0;
  logic [REG_W-1:0] id_rd = '0;
  logic             id_reg_write = 1'b0;
  logic [LAT_W-1:0] id_latency = '0;
  logic             branch_taken = 1'b0;
  logic             mem_wait = 1'b0;
  logic             stall;
  logic             flush;
  logic             busy;
  logic [CNT_W-1:0] stall_count;

  typedef struct {
    int         id;
    logic       stall;
    logic       flush;
    logic       busy;
    logic [3:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;
  bit   done = 1'b0;

  hazard_scoreboard #(
    .NUM_REGS(32), .REG_W(REG_W), .LAT_W(LAT_W), .FLUSH_EXTRA(1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_latency(id_latency),
    .branch_taken(branch_taken), .mem_wait(mem_wait),
    .stall(stall), .flush(flush), .busy(busy), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int id, input logic [15:0] got,
                     input logic [15:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s step %0d got %0h expected %0h", nm, id, got, expv);
    end
  endtask

  // One cycle of stimulus plus the outputs expected during that cycle.
  task automatic step(input logic rst, input logic v,
                      input logic [4:0] r1, input logic u1,
                      input logic [4:0] r2, input logic u2,
                      input logic [4:0] rd, input logic w, input logic [2:0] lat,
                      input logic br, input logic mw,
                      input logic es, input logic ef, input logic eb,
                      input logic [3:0] ec);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n        = ~rst;
    id_valid     = v;
    id_rs1       = r1;
    id_rs1_used  = u1;
    id_rs2       = r2;
    id_rs2_used  = u2;
    id_rd        = rd;
    id_reg_write = w;
    id_latency   = lat;
    branch_taken = br;
    mem_wait     = mw;
    e.id = step_no; e.stall = es; e.flush = ef; e.busy = eb; e.cnt = ec;
    exp_q.push_back(e);
    step_no++;
  endtask

  task automatic idle(input logic br, input logic mw, input logic es,
                      input logic ef, input logic eb, input logic [3:0] ec);
    step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0, br, mw,
         es, ef, eb, ec);
  endtask

  // Monitor: compare the DUT outputs against the oldest queued expectation.
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("stall", e.id, 16'(stall), 16'(e.stall));
        chk("flush", e.id, 16'(flush), 16'(e.flush));
        chk("busy", e.id, 16'(busy), 16'(e.busy));
        chk("stall_count", e.id, 16'(stall_count), 16'(e.cnt));
      end
    end
  end

  initial begin
    // Reset: outputs follow inputs combinationally, state stays cleared.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 4'd0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 4'd0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 1, 0, 4'd0);

    // Load-use: load x5 (lat 1), then add x6,x5,x1 stalls exactly once.
    step(0, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0,  0, 0, 0, 4'd0);
    step(0, 1, 5, 1, 1, 1, 6, 1, 0, 0, 0,  1, 0, 1, 4'd0);
    step(0, 1, 5, 1, 1, 1, 6, 1, 0, 0, 0,  0, 0, 0, 4'd1);

    // Latency 3 on x7 with two mem_wait cycles inside the window: 5 stalls.
    step(0, 1, 0, 0, 0, 0, 7, 1, 3, 0, 0,  0, 0, 0, 4'd1);
    step(0, 1, 7, 1, 0, 0, 9, 1, 0, 0, 0,  1, 0, 1, 4'd1);
    step(0, 1, 7, 1, 0, 0, 9, 1, 0, 0, 1,  1, 0, 1, 4'd2);
    step(0, 1, 7, 1, 0, 0, 9, 1, 0, 0, 1,  1, 0, 1, 4'd3);
    step(0, 1, 7, 1, 0, 0, 9, 1, 0, 0, 0,  1, 0, 1, 4'd4);
    step(0, 1, 7, 1, 0, 0, 9, 1, 0, 0, 0,  1, 0, 1, 4'd5);
    step(0, 1, 7, 1, 0, 0, 9, 1, 0, 0, 0,  0, 0, 0, 4'd6);

    // x0 is never tracked: writing it with latency 7 then reading it is free.
    step(0, 1, 0, 0, 0, 0, 0, 1, 7, 0, 0,  0, 0, 0, 4'd6);
    step(0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0,  0, 0, 0, 4'd6);

    // WAW: x8 pending 3, new writer with latency 1 waits until pend<=1.
    step(0, 1, 0, 0, 0, 0, 8, 1, 3, 0, 0,  0, 0, 0, 4'd6);
    step(0, 1, 0, 0, 0, 0, 8, 1, 1, 0, 0,  1, 0, 1, 4'd6);
    step(0, 1, 0, 0, 0, 0, 8, 1, 1, 0, 0,  1, 0, 1, 4'd7);
    step(0, 1, 0, 0, 0, 0, 8, 1, 1, 0, 0,  0, 0, 1, 4'd8);
    idle(0, 0,  0, 0, 1, 4'd8);   // pend[x8] reloaded to 1 by the issue
    idle(0, 0,  0, 0, 0, 4'd8);

    // Flush window: hazard in ID during flush gives no stall and no pend load.
    step(0, 1, 0, 0, 0, 0, 10, 1, 2, 0, 0, 0, 0, 0, 4'd8);
    step(0, 1, 10, 1, 0, 0, 11, 1, 5, 1, 0, 0, 1, 1, 4'd8);
    step(0, 1, 10, 1, 0, 0, 11, 1, 5, 0, 0, 0, 1, 1, 4'd8);
    idle(0, 0,  0, 0, 0, 4'd8);   // x11 was never loaded

    // Branch held under mem_wait takes effect once memory is ready; window freezes.
    idle(1, 1,  1, 0, 0, 4'd8);
    idle(1, 0,  0, 1, 0, 4'd9);
    idle(0, 1,  1, 0, 0, 4'd9);
    idle(0, 0,  0, 1, 0, 4'd10);
    idle(0, 0,  0, 0, 0, 4'd10);

    // Long memory wait: 4-bit stall counter saturates at 15.
    for (int i = 0; i < 20; i++) begin
      idle(0, 1, 1, 0, 0, (10 + i > 15) ? 4'd15 : 4'(10 + i));
    end
    idle(0, 0,  0, 0, 0, 4'd15);

    // Asynchronous reset mid-window clears pending writes immediately.
    step(0, 1, 0, 0, 0, 0, 12, 1, 7, 0, 0, 0, 0, 0, 4'd15);
    idle(0, 0,  0, 0, 1, 4'd15);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 4'd0);
    step(0, 1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);

    @(posedge clk);
    @(negedge clk);
    #1;
    done = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d expected entries, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard unit for the in-order pipeline: tracks in-flight register writes with per-register countdown timers and generates ID-stage stall and front-end flush. It replaces fixed single-cycle load-use detection with per-instruction result latency, write-after-write protection, memory-wait freeze, a programmable multi-cycle flush window and a saturating stall counter. It sits beside the ID/EX boundary, is fed by decode, EX branch resolution and the data-memory interface, and drives the pipeline-register enables and kills.

## Interface
- NUM_REGS, 32, architectural registers; register 0 is hard-wired zero and never tracked
- REG_W, 5, register index width; $clog2(NUM_REGS)
- LAT_W, 3, latency field width; latencies 0..2^LAT_W-1
- FLUSH_EXTRA, 1, cycles `flush` stays high after the `branch_taken` cycle; 0 gives a single-cycle flush
- CNT_W, 16, stall counter width
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  REG_W  ID source registers
- id_rs1_used, id_rs2_used  in  1  source is actually read
- id_rd  in  REG_W  ID destination register
- id_reg_write  in  1  ID instruction writes `id_rd`
- id_latency  in  LAT_W  bubbles a dependent needs after this instruction issues; ALU = 0, load = 1
- branch_taken  in  1  EX resolved a taken branch or jump
- mem_wait  in  1  data memory not ready; whole pipeline frozen
- stall  out  1  hold PC and IF/ID; insert bubble into EX
- flush  out  1  kill IF and ID contents
- busy  out  1  at least one register has a pending write
- stall_count  out  CNT_W  saturating count of stalled cycles

## Operation
- State: `pend[r]` (LAT_W bits) for r = 1..NUM_REGS-1; `flush_cnt`; `stall_count`.
- raw_hazard = (id_rs1_used && id_rs1!=0 && pend[id_rs1]!=0) || (id_rs2_used && id_rs2!=0 && pend[id_rs2]!=0).
- waw_hazard = id_reg_write && id_rd!=0 && pend[id_rd] > id_latency.
- data_hazard = id_valid && (raw_hazard || waw_hazard).
- flush = !mem_wait && (branch_taken || flush_cnt!=0).
- stall = mem_wait || (data_hazard && !flush). Flush has priority over data stalls because the ID instruction is killed.
- issue = id_valid && !stall && !flush.
- When mem_wait=1, all `pend`, `flush_cnt` and the flush window are frozen. A `branch_taken` held during the wait takes effect on the first cycle with mem_wait=0.
- Per cycle with mem_wait=0:
  - every nonzero `pend[r]` decrements by 1;
  - on issue with id_reg_write and id_rd!=0, `pend[id_rd]` loads `id_latency`. The load overrides the decrement for that register.
- flush_cnt: loads FLUSH_EXTRA when branch_taken && !mem_wait; otherwise decrements if nonzero and !mem_wait. A new branch_taken while the window is open reloads it.
- stall_count increments on every cycle with stall=1 and saturates at 2^CNT_W-1.
- busy = OR of all `pend[r]`!=0.
- id_latency=0 leaves `pend` at 0, so that instruction never causes a stall.

## Timing
- Reset (rst_n low, asynchronous): all `pend`=0, flush_cnt=0, stall_count=0, busy=0.
- While in reset, stall=mem_wait and flush=branch_taken && !mem_wait; both remain purely combinational from inputs and state.
- stall and flush are combinational in the current cycle. State changes are visible in the next cycle.
- A producer with latency L issued at cycle t causes a dependent arriving in ID at t+1 to stall for exactly L cycles. The dependent issues at t+1+L when no mem_wait intervenes.
- Each mem_wait cycle adds exactly one cycle to every pending window.
- flush is high for 1+FLUSH_EXTRA non-waiting cycles per taken branch.
- Reset asserted mid-operation clears every pending entry immediately; no stall persists after release except one caused by mem_wait.

## Test plan
- Reset with branch_taken=0, mem_wait=0 -> stall=0, flush=0, busy=0, stall_count=0.
- Load x5 (latency 1) issues; next cycle `add x6,x5,x1` in ID -> stall=1 for one cycle, issue the cycle after, stall_count=1.
- Producer latency 3 on x7; dependent reads x7 with mem_wait=1 for 2 cycles in between -> 3+2 stalled cycles, then issue; writes to and reads of x0 never stall.
- x8 pending 3, ID writes x8 with latency 1 (WAW) -> stall until pend[x8]<=1; the instruction then issues and pend[x8]=1.
- FLUSH_EXTRA=1: branch_taken pulse at t -> flush high at t and t+1. A data hazard in ID at t gives stall=0, no issue and no `pend` update.
- CNT_W=4: hold mem_wait=1 for 20 cycles -> stall_count saturates at 15. Async rst_n pulse mid-window -> pend cleared, busy=0 immediately.
